// File: rtl/calendar_set_ctrl.sv
// rtl/calendar_set_ctrl.sv - key sequencer and rollover gate for the calendar date counter
module calendar_set_ctrl #(
   parameter int HOLD_CYC    = 25_000_000,
   parameter int REPEAT_CYC  = 5_000_000,
   parameter int TIMEOUT_CYC = 500_000_000,
   parameter int BLINK_CYC   = 12_500_000,
   parameter int CNT_W       = 29
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       key_mode,
   input  logic       key_up,
   input  logic       key_down,
   input  logic       day_full,
   output logic [2:0] cnt_inc,
   output logic [2:0] cnt_dec,
   output logic       full_flag,
   output logic [2:0] sel,
   output logic       set_mode,
   output logic       blink
);

   // Encoding is sequential so that a mode press is a plain +1 that wraps SET_YEAR back to RUN
   localparam logic [1:0] RUN      = 2'd0;
   localparam logic [1:0] SET_DAY  = 2'd1;
   localparam logic [1:0] SET_MON  = 2'd2;
   localparam logic [1:0] SET_YEAR = 2'd3;

   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] HOLD_M1  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] REP_M1   = CNT_W'(REPEAT_CYC - 1);
   localparam logic [CNT_W-1:0] TMO_M1   = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] BLINK_M1 = CNT_W'(BLINK_CYC - 1);

   logic [1:0]       state, state_nx;
   logic             mode_d, up_d, down_d;
   logic [CNT_W-1:0] hold_cnt, idle_cnt, blink_cnt;
   logic [CNT_W-1:0] hold_cnt_nx, idle_cnt_nx, blink_cnt_nx;
   logic             repeating, rep_up, rep_dn, lock, pending, phase;
   logic             repeating_nx, rep_up_nx, rep_dn_nx, phase_nx;
   logic             mode_rise, up_rise, dn_rise, any_key, in_set, timeout, state_chg;
   logic             up_first, dn_first, up_hold, dn_hold, hold_hit, inc_pulse, dec_pulse;
   logic [2:0]       sel_nx;

   // Next-state, pulse qualification and timer next values
   always_comb begin
      mode_rise = key_mode & ~mode_d;
      up_rise   = key_up & ~up_d;
      dn_rise   = key_down & ~down_d;
      any_key   = key_mode | key_up | key_down;
      in_set    = (state != RUN);
      timeout   = in_set & ~any_key & (idle_cnt == TMO_M1);

      state_nx = state;
      if (mode_rise)
         state_nx = state + 2'd1;
      else if (timeout)
         state_nx = RUN;
      state_chg = (state_nx != state);

      case (state_nx)
         SET_DAY:  sel_nx = 3'b001;
         SET_MON:  sel_nx = 3'b010;
         SET_YEAR: sel_nx = 3'b100;
         default:  sel_nx = 3'b000;
      endcase

      // A fresh press only counts when the other key is up and no two-key chord is still latched
      up_first  = in_set & ~state_chg & up_rise & ~key_down & ~lock;
      dn_first  = in_set & ~state_chg & dn_rise & ~key_up & ~lock;
      up_hold   = rep_up & key_up & ~key_down & ~state_chg;
      dn_hold   = rep_dn & key_down & ~key_up & ~state_chg;
      hold_hit  = repeating ? (hold_cnt == REP_M1) : (hold_cnt == HOLD_M1);
      inc_pulse = up_first | (up_hold & hold_hit);
      dec_pulse = dn_first | (dn_hold & hold_hit);

      hold_cnt_nx  = '0;
      repeating_nx = 1'b0;
      rep_up_nx    = 1'b0;
      rep_dn_nx    = 1'b0;
      if (up_first | dn_first) begin
         rep_up_nx = up_first;
         rep_dn_nx = dn_first;
      end else if (up_hold | dn_hold) begin
         rep_up_nx = up_hold;
         rep_dn_nx = dn_hold;
         if (hold_hit) begin
            repeating_nx = 1'b1;
         end else begin
            hold_cnt_nx  = hold_cnt + ONE;
            repeating_nx = repeating;
         end
      end

      idle_cnt_nx = (state_nx == RUN || any_key || state_chg) ? '0 : idle_cnt + ONE;

      blink_cnt_nx = '0;
      phase_nx     = 1'b0;
      if (state_chg) begin
         phase_nx = 1'b1;
      end else if (in_set) begin
         if (blink_cnt == BLINK_M1) begin
            phase_nx = ~phase;
         end else begin
            blink_cnt_nx = blink_cnt + ONE;
            phase_nx     = phase;
         end
      end
   end

   // State, key history and internal timers
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state     <= RUN;
         mode_d    <= 1'b0;
         up_d      <= 1'b0;
         down_d    <= 1'b0;
         hold_cnt  <= '0;
         idle_cnt  <= '0;
         blink_cnt <= '0;
         repeating <= 1'b0;
         rep_up    <= 1'b0;
         rep_dn    <= 1'b0;
         lock      <= 1'b0;
         pending   <= 1'b0;
         phase     <= 1'b0;
      end else begin
         state     <= state_nx;
         mode_d    <= key_mode;
         up_d      <= key_up;
         down_d    <= key_down;
         hold_cnt  <= hold_cnt_nx;
         idle_cnt  <= idle_cnt_nx;
         blink_cnt <= blink_cnt_nx;
         repeating <= repeating_nx;
         rep_up    <= rep_up_nx;
         rep_dn    <= rep_dn_nx;
         lock      <= (lock | (key_up & key_down)) & (key_up | key_down);
         pending   <= (state_nx != RUN) & (pending | day_full);
         phase     <= phase_nx;
      end
   end

   // Registered outputs; a rollover held while editing is released on the first RUN cycle
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         cnt_inc   <= 3'b000;
         cnt_dec   <= 3'b000;
         full_flag <= 1'b0;
         sel       <= 3'b000;
         set_mode  <= 1'b0;
         blink     <= 1'b0;
      end else begin
         cnt_inc   <= inc_pulse ? sel : 3'b000;
         cnt_dec   <= dec_pulse ? sel : 3'b000;
         full_flag <= (state_nx == RUN) & (pending | day_full);
         sel       <= sel_nx;
         set_mode  <= (state_nx != RUN);
         blink     <= (state_nx != RUN) & (phase_nx | key_up | key_down);
      end
   end

endmodule

// File: tb/tb_calendar_set_ctrl.sv
// tb/tb_calendar_set_ctrl.sv - directed self-checking bench for calendar_set_ctrl
module tb_calendar_set_ctrl;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic       key_mode = 1'b0;
   logic       key_up = 1'b0;
   logic       key_down = 1'b0;
   logic       day_full = 1'b0;
   logic [2:0] cnt_inc, cnt_dec, sel;
   logic       full_flag, set_mode, blink;

   int n_tests = 0;
   int n_fail = 0;
   int n_inc, n_dec, n_full, n_set;
   int offs[$];
   int exp_offs[5] = '{1, 21, 26, 31, 36};

   typedef struct {
      logic       m, u, d, f;
      logic [2:0] e_inc, e_dec;
      logic       e_full;
      logic [2:0] e_sel;
      logic       e_set;
   } vec_t;
   vec_t vq[$];

   calendar_set_ctrl #(
      .HOLD_CYC(20), .REPEAT_CYC(5), .TIMEOUT_CYC(50), .BLINK_CYC(4), .CNT_W(8)
   ) dut (
      .Clk(Clk), .Reset(Reset), .key_mode(key_mode), .key_up(key_up), .key_down(key_down),
      .day_full(day_full), .cnt_inc(cnt_inc), .cnt_dec(cnt_dec), .full_flag(full_flag),
      .sel(sel), .set_mode(set_mode), .blink(blink)
   );

   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic press_mode();
      key_mode = 1'b1;
      step();
      key_mode = 1'b0;
      step();
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic add(input logic m, input logic u, input logic d, input logic f,
                      input logic [2:0] ei, input logic [2:0] ed, input logic ef,
                      input logic [2:0] es, input logic est);
      vec_t v;
      v.m = m; v.u = u; v.d = d; v.f = f;
      v.e_inc = ei; v.e_dec = ed; v.e_full = ef; v.e_sel = es; v.e_set = est;
      vq.push_back(v);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      //   mode  up    down  dfull  inc     dec     full  sel     set
      add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 1'b1, 3'b000, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0);
      add(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b001, 1'b1);
      add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b001, 1'b1);
      add(1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 3'b000, 1'b0, 3'b001, 1'b1);
      add(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b001, 1'b1);
      add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b001, 1'b1);
      add(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b001, 1'b0, 3'b001, 1'b1);
      add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b001, 1'b1);
      add(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b010, 1'b1);
      add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b010, 1'b1);
      add(1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 3'b000, 1'b0, 3'b010, 1'b1);
      add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b010, 1'b1);
      add(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b100, 1'b1);
      add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b100, 1'b1);
      add(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b100, 1'b0, 3'b100, 1'b1);
      add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b100, 1'b1);
      add(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 3'b100, 1'b1);
      add(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 3'b100, 1'b1);
      add(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 3'b000, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 3'b000, 1'b0);

      // reset held for 10 cycles
      for (int i = 0; i < 10; i++) step();
      check("rst_sel", 32'(sel), 32'(3'b000));
      check("rst_set", 32'(set_mode), 32'(1'b0));
      Reset = 1'b0;
      step();
      check("idle_inc", 32'(cnt_inc), 32'(3'b000));
      check("idle_dec", 32'(cnt_dec), 32'(3'b000));
      check("idle_full", 32'(full_flag), 32'(1'b0));
      check("idle_blink", 32'(blink), 32'(1'b0));

      // single-cycle vectors
      foreach (vq[i]) begin
         key_mode = vq[i].m; key_up = vq[i].u; key_down = vq[i].d; day_full = vq[i].f;
         step();
         check($sformatf("vec%0d_inc", i), 32'(cnt_inc), 32'(vq[i].e_inc));
         check($sformatf("vec%0d_dec", i), 32'(cnt_dec), 32'(vq[i].e_dec));
         check($sformatf("vec%0d_full", i), 32'(full_flag), 32'(vq[i].e_full));
         check($sformatf("vec%0d_sel", i), 32'(sel), 32'(vq[i].e_sel));
         check($sformatf("vec%0d_set", i), 32'(set_mode), 32'(vq[i].e_set));
      end
      day_full = 1'b0;

      // auto-repeat in SET_MON: 40-cycle hold
      press_mode();
      press_mode();
      check("mon_sel", 32'(sel), 32'(3'b010));
      n_dec = 0;
      for (int k = 0; k < 45; k++) begin
         key_up = (k < 40);
         step();
         if (cnt_inc != 3'b000) begin
            offs.push_back(k + 1);
            check("rep_val", 32'(cnt_inc), 32'(3'b010));
         end
         if (cnt_dec != 3'b000) n_dec++;
      end
      check("rep_count", 32'(offs.size()), 32'd5);
      check("rep_no_dec", 32'(n_dec), 32'd0);
      for (int i = 0; i < 5 && i < offs.size(); i++)
         check($sformatf("rep_off%0d", i), 32'(offs[i]), 32'(exp_offs[i]));

      // down tap gives exactly one pulse
      n_dec = 0;
      for (int k = 0; k < 7; k++) begin
         key_down = (k == 0);
         step();
         if (cnt_dec != 3'b000) begin
            n_dec++;
            check("tap_val", 32'(cnt_dec), 32'(3'b010));
         end
      end
      check("tap_count", 32'(n_dec), 32'd1);
      press_mode();
      press_mode();
      check("back_run", 32'(set_mode), 32'(1'b0));

      // both keys in SET_DAY, then one released while the other stays held
      press_mode();
      n_inc = 0; n_dec = 0;
      for (int k = 0; k < 30; k++) begin
         key_up = 1'b1; key_down = 1'b1;
         step();
         if (cnt_inc != 3'b000) n_inc++;
         if (cnt_dec != 3'b000) n_dec++;
         if (k == 10) check("blink_forced", 32'(blink), 32'(1'b1));
      end
      key_down = 1'b0;
      for (int k = 0; k < 25; k++) begin
         step();
         if (cnt_inc != 3'b000) n_inc++;
         if (cnt_dec != 3'b000) n_dec++;
      end
      key_up = 1'b0;
      step();
      check("both_inc", 32'(n_inc), 32'd0);
      check("both_dec", 32'(n_dec), 32'd0);
      key_up = 1'b1;
      step();
      check("repress_inc", 32'(cnt_inc), 32'(3'b001));
      key_up = 1'b0;
      step();
      press_mode();
      press_mode();
      press_mode();
      check("run_again", 32'(sel), 32'(3'b000));

      // blink pattern and timeout in SET_DAY
      key_mode = 1'b1;
      step();
      key_mode = 1'b0;
      check("tmo_sel", 32'(sel), 32'(3'b001));
      for (int c = 1; c <= 12; c++) begin
         if (c > 1) step();
         check($sformatf("blink_c%0d", c), 32'(blink), 32'((((c - 1) / 4) % 2) == 0));
      end
      n_set = 12;
      for (int k = 0; k < 100 && set_mode; k++) begin
         step();
         if (set_mode) n_set++;
      end
      check("tmo_cycles", 32'(n_set), 32'd50);
      check("tmo_sel_run", 32'(sel), 32'(3'b000));
      check("tmo_blink", 32'(blink), 32'(1'b0));

      // reset mid-edit discards a pending rollover
      press_mode();
      day_full = 1'b1;
      step();
      day_full = 1'b0;
      check("pend_full", 32'(full_flag), 32'(1'b0));
      step();
      Reset = 1'b1;
      #2;
      check("midrst_set", 32'(set_mode), 32'(1'b0));
      check("midrst_sel", 32'(sel), 32'(3'b000));
      step();
      step();
      Reset = 1'b0;
      n_full = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (full_flag) n_full++;
      end
      check("midrst_nofull", 32'(n_full), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
